// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, 15-entry register file,
// source/destination decode and the operand forwarding network.
module decode_stage #(
  parameter logic [3:0] RSP_ID = 4'd4,
  parameter logic [3:0] RNONE  = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [63:0] D_valC,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB
);

  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic [3:0]  d_ra;
  logic [3:0]  d_rb;
  logic [63:0] d_valp;
  logic [63:0] regs [0:14];
  logic [63:0] rf_a;
  logic [63:0] rf_b;

  // Reset and bubble both load a nop; stall outranks bubble.
  always_ff @(posedge clk) begin
    if (reset || (D_bubble && !D_stall)) begin
      D_stat  <= STAT_AOK;
      D_icode <= I_NOP;
      D_ifun  <= 4'h0;
      d_ra    <= RNONE;
      d_rb    <= RNONE;
      D_valC  <= 64'h0;
      d_valp  <= 64'h0;
    end else if (!D_stall) begin
      D_stat  <= f_stat;
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      d_ra    <= f_rA;
      d_rb    <= f_rB;
      D_valC  <= f_valC;
      d_valp  <= f_valP;
    end
  end

  // The M-port write is issued last so it wins when both ports hit one id.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= 64'h0;
      end
    end else begin
      if (W_dstE != RNONE) begin
        regs[W_dstE] <= W_valE;
      end
      if (W_dstM != RNONE) begin
        regs[W_dstM] <= W_valM;
      end
    end
  end

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin
        d_srcA = d_ra;
        d_dstE = d_rb;
      end
      I_IRMOVQ: d_dstE = d_rb;
      I_RMMOVQ: begin
        d_srcA = d_ra;
        d_srcB = d_rb;
      end
      I_MRMOVQ: begin
        d_srcB = d_rb;
        d_dstM = d_ra;
      end
      I_OPQ: begin
        d_srcA = d_ra;
        d_srcB = d_rb;
        d_dstE = d_rb;
      end
      I_CALL: begin
        d_srcB = RSP_ID;
        d_dstE = RSP_ID;
      end
      I_RET: begin
        d_srcA = RSP_ID;
        d_srcB = RSP_ID;
        d_dstE = RSP_ID;
      end
      I_PUSHQ: begin
        d_srcA = d_ra;
        d_srcB = RSP_ID;
        d_dstE = RSP_ID;
      end
      I_POPQ: begin
        d_srcA = RSP_ID;
        d_srcB = RSP_ID;
        d_dstE = RSP_ID;
        d_dstM = d_ra;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_a = 64'h0;
    rf_b = 64'h0;
    if (d_srcA != RNONE) begin
      rf_a = regs[d_srcA];
    end
    if (d_srcB != RNONE) begin
      rf_b = regs[d_srcB];
    end
  end

  // Youngest producer first; the W entries cover this cycle's register write.
  always_comb begin
    if (D_icode == I_JXX || D_icode == I_CALL) begin
      d_valA = d_valp;
    end else if (d_srcA == RNONE) begin
      d_valA = 64'h0;
    end else if (d_srcA == e_dstE) begin
      d_valA = e_valE;
    end else if (d_srcA == M_dstM) begin
      d_valA = m_valM;
    end else if (d_srcA == M_dstE) begin
      d_valA = M_valE;
    end else if (d_srcA == W_dstM) begin
      d_valA = W_valM;
    end else if (d_srcA == W_dstE) begin
      d_valA = W_valE;
    end else begin
      d_valA = rf_a;
    end
  end

  always_comb begin
    if (d_srcB == RNONE) begin
      d_valB = 64'h0;
    end else if (d_srcB == e_dstE) begin
      d_valB = e_valE;
    end else if (d_srcB == M_dstM) begin
      d_valB = m_valM;
    end else if (d_srcB == M_dstE) begin
      d_valB = M_valE;
    end else if (d_srcB == W_dstM) begin
      d_valB = W_valM;
    end else if (d_srcB == W_dstE) begin
      d_valB = W_valE;
    end else begin
      d_valB = rf_b;
    end
  end

endmodule
